// File: rtl/led7seg_pkg.sv
// Shared constants and helpers for the scanned 7-segment display driver.
// Segment codes are active-high {a,b,c,d,e,f,g} with a in bit 6.
package led7seg_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef logic [SEG_W-1:0] seg_code_t;

  // Every segment lit, built from the segment positions so the code word
  // stays consistent with the index constants above.
  localparam seg_code_t SEG_MASK_ALL = (seg_code_t'(1) << SEG_A) |
                                       (seg_code_t'(1) << SEG_B) |
                                       (seg_code_t'(1) << SEG_C) |
                                       (seg_code_t'(1) << SEG_D) |
                                       (seg_code_t'(1) << SEG_E) |
                                       (seg_code_t'(1) << SEG_F) |
                                       (seg_code_t'(1) << SEG_G);

  // Hex glyphs 0-F, active-high abcdefg.
  localparam seg_code_t SEG_TABLE [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  // Active-high segment pattern for one hex nibble.
  function automatic seg_code_t hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/led7seg_scan_timer.sv
// Scan timing for the multiplexed display: slot prescaler, digit index,
// frame-start pulse and the per-cycle boundary / dead-time flags.
module led7seg_scan_timer
  import led7seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 1,
  parameter int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_dead,
  output logic             o_boundary,
  output logic             o_frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_frame_tick;

  logic w_cnt_wrap;
  logic w_idx_last;
  logic w_frame_start;

  // Decode of the current (idx, cnt) position within the frame.
  always_comb begin
    w_cnt_wrap    = (r_cnt == CNT_MAX);
    w_idx_last    = (r_idx == IDX_MAX);
    w_frame_start = (r_cnt == {CNT_W{1'b0}}) && (r_idx == {IDX_W{1'b0}});
  end

  // Slot prescaler; the digit index advances each time the prescaler wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {CNT_W{1'b0}};
      r_idx <= {IDX_W{1'b0}};
    end else if (w_cnt_wrap) begin
      r_cnt <= {CNT_W{1'b0}};
      if (w_idx_last) begin
        r_idx <= {IDX_W{1'b0}};
      end else begin
        r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Registered frame-start pulse, aligned with the registered display outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_start;
    end
  end

  assign o_idx        = r_idx;
  assign o_dead       = (r_cnt < CNT_DEAD);
  assign o_boundary   = w_cnt_wrap && w_idx_last;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: rtl/led7seg_scan_anode.sv
// N-digit time-multiplexed common-anode 7-segment driver with tear-free
// frame-synchronous update, leading-zero suppression and anti-ghost dead time.
module led7seg_scan_anode
  import led7seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYC       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*N_DIGITS-1:0] i_value_in,
  input  logic [N_DIGITS-1:0]   i_dp_in,
  input  logic [N_DIGITS-1:0]   i_blank_in,
  input  logic                  i_lz_en,
  input  logic                  i_load,
  output logic [SEG_W-1:0]      o_seg,
  output logic                  o_dp_out,
  output logic [N_DIGITS-1:0]   o_dig_en,
  output logic                  o_frame_tick,
  output logic                  o_pending
);

  localparam int VAL_W = 4 * N_DIGITS;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  // Pin levels that mean "off" for the configured driver polarity.
  localparam seg_code_t           SEG_OFF = (SEG_ACTIVE_LOW != 0) ? SEG_MASK_ALL : {SEG_W{1'b0}};
  localparam logic                DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [N_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  // Shadow frame: written by load, waits for the next frame boundary.
  logic [VAL_W-1:0]    r_sh_value;
  logic [N_DIGITS-1:0] r_sh_dp;
  logic [N_DIGITS-1:0] r_sh_blank;
  logic                r_sh_lz;

  // Active frame: what is currently being scanned out.
  logic [VAL_W-1:0]    r_act_value;
  logic [N_DIGITS-1:0] r_act_dp;
  logic [N_DIGITS-1:0] r_act_blank;
  logic                r_act_lz;

  logic                r_pending;

  logic [SEG_W-1:0]    r_seg;
  logic                r_dp_out;
  logic [N_DIGITS-1:0] r_dig_en;

  logic [IDX_W-1:0]    w_idx;
  logic                w_dead;
  logic                w_boundary;
  logic                w_frame_tick;

  logic [3:0]          w_nibble;
  logic [N_DIGITS-1:0] w_upper_zero;
  logic [N_DIGITS-1:0] w_onehot;
  logic                w_lz_dark;
  logic                w_dig_dark;
  seg_code_t           w_glyph;
  logic [SEG_W-1:0]    w_seg_nxt;
  logic                w_dp_nxt;
  logic [N_DIGITS-1:0] w_dig_nxt;

  led7seg_scan_timer #(
    .N_DIGITS (N_DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .DEAD_CYC (DEAD_CYC),
    .IDX_W    (IDX_W)
  ) u_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_idx        (w_idx),
    .o_dead       (w_dead),
    .o_boundary   (w_boundary),
    .o_frame_tick (w_frame_tick)
  );

  // Shadow capture on load; shadow moves to active only at a frame boundary.
  // A load that lands on the boundary refills the shadow after the transfer,
  // so pending stays set and that data waits one more frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh_value  <= {VAL_W{1'b0}};
      r_sh_dp     <= {N_DIGITS{1'b0}};
      r_sh_blank  <= {N_DIGITS{1'b0}};
      r_sh_lz     <= 1'b0;
      r_act_value <= {VAL_W{1'b0}};
      r_act_dp    <= {N_DIGITS{1'b0}};
      r_act_blank <= {N_DIGITS{1'b0}};
      r_act_lz    <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      if (i_load) begin
        r_sh_value <= i_value_in;
        r_sh_dp    <= i_dp_in;
        r_sh_blank <= i_blank_in;
        r_sh_lz    <= i_lz_en;
      end
      if (w_boundary && r_pending) begin
        r_act_value <= r_sh_value;
        r_act_dp    <= r_sh_dp;
        r_act_blank <= r_sh_blank;
        r_act_lz    <= r_sh_lz;
      end
      if (i_load) begin
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

  // For each digit position: are this nibble and every nibble above it zero?
  always_comb begin
    w_upper_zero = {N_DIGITS{1'b0}};
    for (int k = 0; k < N_DIGITS; k++) begin
      w_upper_zero[k] = ((r_act_value >> (4 * k)) == {VAL_W{1'b0}});
    end
  end

  // One-hot of the digit currently being scanned.
  always_comb begin
    w_onehot = {N_DIGITS{1'b0}};
    for (int k = 0; k < N_DIGITS; k++) begin
      w_onehot[k] = (w_idx == IDX_W'(k));
    end
  end

  // Select the scanned digit's glyph and decide whether it is dark.
  // Digit 0 is exempt from leading-zero suppression so a zero value shows "0".
  always_comb begin
    w_nibble   = r_act_value[4*w_idx +: 4];
    w_glyph    = hex_to_seg(w_nibble);
    w_lz_dark  = r_act_lz && (w_idx != {IDX_W{1'b0}}) && w_upper_zero[w_idx];
    w_dig_dark = r_act_blank[w_idx] || w_lz_dark;
  end

  // Next pin levels: all off during dead time, else one digit enabled with
  // its glyph (or dark segments and dp when blanked or suppressed).
  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = DP_OFF;
    w_dig_nxt = DIG_OFF;
    if (w_dead) begin
      w_seg_nxt = SEG_OFF;
      w_dp_nxt  = DP_OFF;
      w_dig_nxt = DIG_OFF;
    end else begin
      w_dig_nxt = (DIG_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
      if (w_dig_dark) begin
        w_seg_nxt = SEG_OFF;
        w_dp_nxt  = DP_OFF;
      end else begin
        w_seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~w_glyph : w_glyph;
        w_dp_nxt  = (SEG_ACTIVE_LOW != 0) ? ~r_act_dp[w_idx] : r_act_dp[w_idx];
      end
    end
  end

  // Output registers driving the display pins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg    <= SEG_OFF;
      r_dp_out <= DP_OFF;
      r_dig_en <= DIG_OFF;
    end else begin
      r_seg    <= w_seg_nxt;
      r_dp_out <= w_dp_nxt;
      r_dig_en <= w_dig_nxt;
    end
  end

  assign o_seg        = r_seg;
  assign o_dp_out     = r_dp_out;
  assign o_dig_en     = r_dig_en;
  assign o_frame_tick = w_frame_tick;
  assign o_pending    = r_pending;

endmodule

// File: tb/tb_led7seg_scan_anode.sv
// Self-checking bench for led7seg_scan_anode (4 digits, 4-cycle slots,
// 1 dead cycle) against a time-based behavioural model of the display.
module tb_led7seg_scan_anode;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int FRAME = N * SD;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_en;
  logic        load;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  dig_en;
  logic        frame_tick;
  logic        pending;

  int checks = 0;
  int errors = 0;

  // Active-high abcdefg glyphs for 0-F.
  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Model state: cycles since reset release plus the two frame buffers.
  int          m_t;
  logic [15:0] sh_v, act_v;
  logic [3:0]  sh_dp, act_dp, sh_bl, act_bl;
  logic        sh_lz, act_lz, m_pend;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_dig;
  logic        e_ft;

  led7seg_scan_anode #(
    .N_DIGITS       (N),
    .SCAN_DIV       (SD),
    .DEAD_CYC       (DC),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_value_in   (value_in),
    .i_dp_in      (dp_in),
    .i_blank_in   (blank_in),
    .i_lz_en      (lz_en),
    .i_load       (load),
    .o_seg        (seg),
    .o_dp_out     (dp_out),
    .o_dig_en     (dig_en),
    .o_frame_tick (frame_tick),
    .o_pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Number of significant hex digits (0 for a zero value).
  function automatic int sig_digits(input logic [15:0] v);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) begin
      if (v[4*k +: 4] != 4'h0) s = k + 1;
    end
    return s;
  endfunction

  // One clock: advance the model by the rules, then compare every output.
  task automatic tick();
    int pos, d;
    bit bnd, dark;
    logic [3:0] nib;
    @(posedge clk);
    if (rst) begin
      m_t = 0;
      sh_v = 16'h0; sh_dp = 4'h0; sh_bl = 4'h0; sh_lz = 1'b0;
      act_v = 16'h0; act_dp = 4'h0; act_bl = 4'h0; act_lz = 1'b0;
      m_pend = 1'b0;
      e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF; e_ft = 1'b0;
    end else begin
      pos  = m_t % SD;
      d    = (m_t / SD) % N;
      e_ft = (pos == 0) && (d == 0);
      if (pos < DC) begin
        e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF;
      end else begin
        e_dig = 4'hF ^ (4'b0001 << d);
        nib   = act_v[4*d +: 4];
        dark  = act_bl[d] || (act_lz && d != 0 && d >= sig_digits(act_v));
        e_seg = dark ? 7'h7F : ~glyph[nib];
        e_dp  = dark ? 1'b1 : ~act_dp[d];
      end
      bnd = (pos == SD - 1) && (d == N - 1);
      if (bnd && m_pend) begin
        act_v = sh_v; act_dp = sh_dp; act_bl = sh_bl; act_lz = sh_lz;
      end
      if (load) begin
        sh_v = value_in; sh_dp = dp_in; sh_bl = blank_in; sh_lz = lz_en;
        m_pend = 1'b1;
      end else if (bnd) begin
        m_pend = 1'b0;
      end
      m_t++;
    end
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("dp_out", 32'(dp_out), 32'(e_dp));
    check("dig_en", 32'(dig_en), 32'(e_dig));
    check("frame_tick", 32'(frame_tick), 32'(e_ft));
    check("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next clock edge will be at frame phase p.
  task automatic wait_phase(input int p);
    for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != p; i++) tick();
  endtask

  task automatic load_frame(input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] bl, input logic lz);
    value_in = v; dp_in = dp; blank_in = bl; lz_en = lz;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; value_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
    lz_en = 1'b0; load = 1'b0;
    run(3);
    rst = 1'b0;
    tick();
    check("first_tick", 32'(frame_tick), 32'd1);
    run(20);

    // Basic scan of 0x1234.
    load_frame(16'h1234, 4'h0, 4'h0, 1'b0);
    run(2 * FRAME + 3);

    // Reset mid-scan, then restart.
    wait_phase(6);
    rst = 1'b1;
    run(3);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dig", 32'(dig_en), 32'hF);
    rst = 1'b0;
    tick();
    check("rst_first_tick", 32'(frame_tick), 32'd1);
    run(5);

    // Tear-free: mid-frame loads only show from the next frame, last wins.
    load_frame(16'h1234, 4'h0, 4'h0, 1'b0);
    run(2 * FRAME);
    wait_phase(8);
    load_frame(16'hABCD, 4'h0, 4'h0, 1'b0);
    run(2);
    load_frame(16'h5678, 4'h0, 4'h0, 1'b0);
    run(2 * FRAME);

    // Load exactly on the boundary cycle.
    wait_phase(3);
    load_frame(16'h4321, 4'h0, 4'h0, 1'b0);
    wait_phase(FRAME - 1);
    load_frame(16'h9999, 4'h0, 4'h0, 1'b0);
    run(2 * FRAME + 2);

    // Leading-zero suppression.
    load_frame(16'h0050, 4'h0, 4'h0, 1'b1);
    run(2 * FRAME);
    load_frame(16'h0000, 4'h0, 4'h0, 1'b1);
    run(2 * FRAME);

    // Blank and decimal points.
    load_frame(16'h8888, 4'b0110, 4'b0100, 1'b0);
    run(2 * FRAME);

    // Randomised loads with occasional reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        run(2);
        rst = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) begin
        load_frame(($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
                   4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                   1'($urandom));
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led7seg_scan_anode.md
Name: led7seg_scan_anode

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display; successor to the single-digit combinational anode decoder.
- Takes a packed hex value plus per-digit decimal-point and blank masks, then scans one digit per slot at a programmable refresh rate.
- Adds tear-free frame-synchronous update, leading-zero suppression and an anti-ghosting dead time.
- Sits between the datapath and the board display pins.

Parameters:
- N_DIGITS, 4: number of digits scanned; must be at least 1.
- SCAN_DIV, 50000: clock cycles per digit slot; must be at least 2.
- DEAD_CYC, 1: cycles at the start of each slot with all digits off; must be less than SCAN_DIV.
- SEG_ACTIVE_LOW, 1: 1 means seg and dp pins are active-low (common anode).
- DIG_ACTIVE_LOW, 1: 1 means dig_en pins are active-low (PNP anode drivers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- value_in  in  4*N_DIGITS  hex nibbles; nibble k drives digit k, digit 0 is the rightmost.
- dp_in  in  N_DIGITS  decimal-point request per digit.
- blank_in  in  N_DIGITS  forces digit k dark.
- lz_en  in  1  leading-zero suppression enable; sampled with load.
- load  in  1  single-cycle strobe; captures value_in, dp_in, blank_in and lz_en.
- seg  out  7  segments {a,b,c,d,e,f,g}; seg[6]=a, seg[0]=g.
- dp_out  out  1  decimal-point segment.
- dig_en  out  N_DIGITS  one-hot digit enable.
- frame_tick  out  1  one-cycle pulse when digit 0's slot begins.
- pending  out  1  a loaded frame is waiting to be applied.

Behaviour:
- Reset (any cycle, including mid-frame):
  - prescaler cnt and digit index idx go to 0.
  - Shadow and active registers are cleared; pending goes to 0.
  - seg and dp_out go to inactive (7'h7F and 1 when active-low).
  - dig_en goes to all-inactive (all ones when active-low).
  - frame_tick goes to 0.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - When cnt wraps, idx increments; idx wraps from N_DIGITS-1 to 0.
  - Frame period is N_DIGITS*SCAN_DIV cycles.
- Load:
  - When load=1, the inputs are captured into the shadow register and pending is set the next cycle.
  - Repeated loads before a frame boundary overwrite the shadow; the last one wins.
- Frame boundary (cnt=SCAN_DIV-1 and idx=N_DIGITS-1):
  - If pending=1, active <= shadow and pending clears.
  - If load is also asserted that cycle, the new data goes to the shadow and pending stays 1. The data captured by that load is not applied this boundary.
  - Mid-frame loads never change what is displayed in the current frame.
- frame_tick is registered and is high for exactly the cycle in which idx=0 and cnt=0.
- Output timing:
  - All outputs are registered and reflect the (idx, cnt) of the previous cycle, i.e. 1-cycle latency.
  - While cnt < DEAD_CYC, dig_en is all-inactive and seg/dp_out are inactive.
  - Otherwise only bit idx of dig_en is active.
- Digit k appears dark (seg and dp inactive, dig_en still active) if any of these hold:
  - blank[k]=1.
  - lz=1, k is not 0, and every nibble from k up to N_DIGITS-1 equals 0.
  - Digit 0 is never suppressed by lz; a value of 0 shows a single "0".
  - dp[k] is still suppressed on a dark digit.
- Decode table, active-high abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - The result is inverted when SEG_ACTIVE_LOW=1.

Decomposition:
- Package led7seg_pkg holds:
  - the 16-entry segment table constant and a function hex_to_seg(nibble) returning the active-high code;
  - SEG_W=7 and the segment-index constants SEG_A..SEG_G.
- One sub-module, led7seg_scan_timer, owns cnt, idx, frame_tick and the boundary/dead-time flags. The top holds the shadow/active registers, lz logic and output registers.

Test Plan:
- Reset: hold rst 3 cycles mid-scan -> seg=7'h7F, dp_out=1, dig_en=4'hF, frame_tick=0, pending=0; after release, first frame_tick exactly 1 cycle later with idx=0.
- Scan (N=4, SCAN_DIV=4, DEAD_CYC=1): load 0x1234 -> pending=1 until boundary; then per slot one dark cycle, then digit 0: dig_en=4'b1110, seg=7'b1001100 ("4"); frame_tick every 16 cycles.
- Tear-free: display 0x1234, load 0xABCD during slot 2, then 0x5678 before the boundary -> slots 2-3 still show "2","1"; the next frame shows 0x5678; 0xABCD is never displayed.
- Boundary collision: load 0x9999 exactly on the boundary cycle -> the old shadow is applied, pending stays 1, and 0x9999 appears one frame later.
- Leading zeros: lz_en=1 with 0x0050 -> digits 3 and 2 dark, digit 1="5" (7'b0100100), digit 0="0"; with 0x0000 -> only digit 0 lit, showing "0".
- Blank/dp: blank_in=4'b0100, dp_in=4'b0110, value 0x8888 -> digit 2 dark with dp_out=1 (off); digit 1 shows "8" with dp_out=0; digits 0 and 3 show "8" with dp_out=1.
